// File: rtl/umich_alu_arbiter_if.sv
// Request/response bundle between NREQ ALU clients and the shared-operator arbiter.
interface umich_alu_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [3*NREQ-1:0]    req_op;
  logic [64*NREQ-1:0]   req_a;
  logic [64*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [63:0]          rsp_data;
  logic                 rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/umich_alu_arbiter.sv
// Round-robin arbiter sharing one 64-bit ALU (add/sub/mult/compare/shift) among NREQ clients.
// Define UMICH_ALU_ARB_MULT_EN to build the multiplier; otherwise opcode 2 returns an error.
//
// state  | meaning
// S_IDLE | scanning requests from ptr, grant issued combinationally
// S_EXEC | operands latched, counting down the opcode latency
// S_RESP | result held on rsp_data/rsp_err until the owner accepts
module umich_alu_arbiter #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 3
) (
  input  logic               clocked_on,
  input  logic               synch_clear,
  umich_alu_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);
`ifdef UMICH_ALU_ARB_MULT_EN
  localparam bit MULT_EN = 1'b1;
`else
  localparam bit MULT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, idx_r, winner;
  logic [2:0]      op_r;
  logic [63:0]     a_r, b_r, data_r, res;
  logic            err_r, err;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] ready, valid_oh;
  logic            load, done;

  function automatic logic [IW-1:0] pick(input logic [NREQ-1:0] v, input logic [IW-1:0] p);
    logic [IW-1:0] w;
    logic          hit;
    int            j;
    w   = '0;
    hit = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(p) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!hit && v[j]) begin
        hit = 1'b1;
        w   = IW'(j);
      end
    end
    return w;
  endfunction

  assign winner = pick(bus.req_valid, ptr);

  always_comb begin
    state_nxt = state;
    ready     = '0;
    load      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (|bus.req_valid) begin
        ready[winner] = 1'b1;
        load          = 1'b1;
        state_nxt     = S_EXEC;
      end
      S_EXEC: if (cnt == CW'(1)) begin
        done      = 1'b1;
        state_nxt = S_RESP;
      end
      S_RESP: if (bus.rsp_ready[idx_r]) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (synch_clear) ready = '0;
  end

  always_comb begin
    valid_oh = '0;
    if (state == S_RESP) valid_oh[idx_r] = 1'b1;
  end

  // The operator is purely combinational on the latched operands; MULT gets MUL_LAT cycles to settle.
  always_comb begin
    res = '0;
    err = 1'b0;
    case (op_r)
      3'd0: res = a_r + b_r;
      3'd1: res = a_r - b_r;
`ifdef UMICH_ALU_ARB_MULT_EN
      3'd2: res = a_r * b_r;
`else
      3'd2: err = 1'b1;
`endif
      3'd3: res = {63'd0, a_r < b_r};
      3'd4: res = {63'd0, $signed(a_r) < $signed(b_r)};
      3'd5: res = {63'd0, a_r == b_r};
      3'd6: res = {63'd0, a_r != b_r};
      3'd7: res = (|b_r[63:6]) ? 64'd0 : (a_r << b_r[5:0]);
      default: res = '0;
    endcase
  end

  always_ff @(posedge clocked_on) begin
    if (synch_clear) begin
      state  <= S_IDLE;
      ptr    <= '0;
      idx_r  <= '0;
      op_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      cnt    <= '0;
      data_r <= '0;
      err_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        idx_r <= winner;
        op_r  <= bus.req_op[3*winner +: 3];
        a_r   <= bus.req_a[64*winner +: 64];
        b_r   <= bus.req_b[64*winner +: 64];
        cnt   <= (MULT_EN && bus.req_op[3*winner +: 3] == 3'd2) ? CW'(MUL_LAT) : CW'(1);
      end else if (state == S_EXEC) begin
        cnt <= cnt - CW'(1);
      end
      if (done) begin
        data_r <= res;
        err_r  <= err;
      end
      if (state == S_RESP && state_nxt == S_IDLE)
        ptr <= (idx_r == IW'(NREQ - 1)) ? '0 : idx_r + IW'(1);
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = valid_oh;
  assign bus.rsp_data  = data_r;
  assign bus.rsp_err   = err_r;
endmodule

// File: tb/tb_umich_alu_arbiter.sv
// Randomized bench for umich_alu_arbiter against a transaction-level round-robin/ALU model.
module tb_umich_alu_arbiter;
  localparam int NREQ    = 4;
  localparam int MUL_LAT = 3;
`ifdef UMICH_ALU_ARB_MULT_EN
  localparam bit MULT_EN = 1'b1;
`else
  localparam bit MULT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  umich_alu_arbiter_if #(.NREQ(NREQ)) bus();
  umich_alu_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
    .clocked_on (clk),
    .synch_clear(rst),
    .bus        (bus)
  );

  int total = 0;
  int bad   = 0;
  int ptr_m = 0;
  logic [2:0]  op_q[NREQ];
  logic [63:0] a_q[NREQ];
  logic [63:0] b_q[NREQ];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [64:0] ref_alu(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      3'd0: return {1'b0, a + b};
      3'd1: return {1'b0, a - b};
      3'd2: return MULT_EN ? {1'b0, a * b} : {1'b1, 64'd0};
      3'd3: return {1'b0, 64'(a < b)};
      3'd4: return {1'b0, 64'($signed(a) < $signed(b))};
      3'd5: return {1'b0, 64'(a == b)};
      3'd6: return {1'b0, 64'(a != b)};
      default: return (b >= 64) ? 65'd0 : {1'b0, a << b};
    endcase
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_op[3*i +: 3]  = op_q[i];
      bus.req_a[64*i +: 64] = a_q[i];
      bus.req_b[64*i +: 64] = b_q[i];
    end
  endtask

  task automatic run_op(input logic [NREQ-1:0] vmask, input int rdelay);
    int              w, cyc, exp_lat;
    logic [64:0]     exp;
    logic [NREQ-1:0] want;
    @(negedge clk);
    bus.rsp_ready = '0;
    drive_ops();
    bus.req_valid = vmask;
    #1;
    w = rr_pick(vmask, ptr_m);
    want = '0;
    want[w] = 1'b1;
    chk("grant", 64'(bus.req_ready), 64'(want));
    exp     = ref_alu(op_q[w], a_q[w], b_q[w]);
    exp_lat = (MULT_EN && op_q[w] == 3'd2) ? 1 + MUL_LAT : 2;
    cyc = 0;
    while (cyc < 30) begin
      @(negedge clk); #1;
      cyc++;
      if (bus.rsp_valid != '0) break;
      chk("ready_busy", 64'(bus.req_ready), 64'd0);
    end
    chk("latency", 64'(cyc), 64'(exp_lat));
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(want));
    chk("rsp_data", bus.rsp_data, exp[63:0]);
    chk("rsp_err", 64'(bus.rsp_err), 64'(exp[64]));
    for (int i = 0; i < rdelay; i++) begin
      @(negedge clk);
      bus.rsp_ready = NREQ'($urandom) & ~want;
      #1;
      chk("hold_valid", 64'(bus.rsp_valid), 64'(want));
      chk("hold_data", bus.rsp_data, exp[63:0]);
      chk("hold_ready", 64'(bus.req_ready), 64'd0);
    end
    @(negedge clk);
    bus.rsp_ready = want | NREQ'($urandom);
    ptr_m = (w + 1) % NREQ;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      op_q[i] = 3'($urandom_range(0, 7));
      a_q[i]  = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       b_q[i] = a_q[i];
        1:       b_q[i] = 64'($urandom_range(0, 70));
        2:       b_q[i] = {$urandom, $urandom};
        default: b_q[i] = ~a_q[i];
      endcase
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      op_q[i] = 3'd0; a_q[i] = 64'd0; b_q[i] = 64'd0;
    end
    drive_ops();

    rst = 1'b1;
    bus.req_valid = '1;
    repeat (2) begin
      @(negedge clk); #1;
      chk("rst_ready", 64'(bus.req_ready), 64'd0);
    end
    chk("rst_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_data", bus.rsp_data, 64'd0);
    chk("rst_err", 64'(bus.rsp_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = '0;
    ptr_m = 0;
    rand_ops();
    run_op('1, 0);

    op_q[2] = 3'd0; a_q[2] = 64'hFFFF_FFFF_FFFF_FFFF; b_q[2] = 64'd2;
    run_op(4'b0100, 0);

    for (int n = 0; n < 5; n++) begin
      rand_ops();
      run_op('1, 0);
    end

    op_q[1] = 3'd2; a_q[1] = 64'h1_0000_0000; b_q[1] = 64'h1_0000_0001;
    run_op(4'b0010, 1);

    op_q[3] = 3'd4; a_q[3] = '1; b_q[3] = 64'd0;  run_op(4'b1000, 0);
    op_q[3] = 3'd3;                               run_op(4'b1000, 0);
    op_q[3] = 3'd7; a_q[3] = 64'd1; b_q[3] = 64'd64; run_op(4'b1000, 0);
    b_q[3] = 64'd63;                              run_op(4'b1000, 0);
    op_q[3] = 3'd5; b_q[3] = 64'd1;               run_op(4'b1000, 0);
    op_q[3] = 3'd6;                               run_op(4'b1000, 0);

    rand_ops();
    run_op(4'b1011, 5);

    @(negedge clk);
    bus.rsp_ready = '0;
    op_q[0] = 3'd0; a_q[0] = 64'd5; b_q[0] = 64'd6;
    drive_ops();
    bus.req_valid = 4'b0001;
    #1;
    chk("abort_grant", 64'(bus.req_ready), 64'(4'b0001));
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_no_rsp0", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk); #1;
    chk("abort_no_rsp1", 64'(bus.rsp_valid), 64'd0);
    bus.req_valid = '1;
    #1;
    chk("abort_idle", 64'(bus.req_ready), 64'(4'b0001));
    bus.req_valid = '0;
    ptr_m = 0;

    for (int n = 0; n < 40; n++) begin
      rand_ops();
      run_op(NREQ'($urandom_range(1, 15)), $urandom_range(0, 3));
    end

    @(negedge clk);
    bus.rsp_ready = '0;
    bus.req_valid = '0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
